// File: rtl/field_packer_if.sv
// ============================================================================
// Module : field_packer_if
// Brief  : Field-input / word-output handshake bundle for field_packer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface field_packer_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 8
);
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

`default_nettype wire

// File: rtl/field_packer.sv
// ============================================================================
// Module : field_packer
// Brief  : Packs IN_W-bit fields MSB-first into OUT_W-bit words; flush emits a
//          padded final word tagged out_last.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module field_packer #(
  parameter int   IN_W    = 5,
  parameter int   OUT_W   = 8,
  parameter logic PAD_BIT = 1'b1,
  parameter int   CNT_W   = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  field_packer_if.slave         bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam int ACC_W  = OUT_W + IN_W;
  localparam int FILL_W = $clog2(ACC_W + 1);

  localparam logic [FILL_W-1:0] C_OUT_W   = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] C_IN_W    = FILL_W'(IN_W);
  localparam logic [ACC_W-1:0]  C_PAD_ALL = {ACC_W{PAD_BIT}};
  localparam logic [ACC_W-1:0]  C_PAD_LOW = ACC_W'({OUT_W{PAD_BIT}});
  localparam logic [ACC_W-1:0]  C_IN_MASK = ACC_W'({IN_W{1'b1}});

  if (IN_W < 1 || IN_W > 32) begin : g_bad_in_w
    $error("field_packer: IN_W must be in 1..32");
  end
  if (OUT_W < 1 || OUT_W > 32) begin : g_bad_out_w
    $error("field_packer: OUT_W must be in 1..32");
  end

  logic [ACC_W-1:0]  acc_q,       acc_d;
  logic [FILL_W-1:0] fill_q,      fill_d;
  logic              flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]  word_cnt_q,  word_cnt_d;

  logic              w_push;
  logic              w_pop;
  logic [FILL_W-1:0] w_shift;

  assign bus.in_ready  = (fill_q < C_OUT_W) && !flush_pend_q;
  assign bus.out_valid = (fill_q >= C_OUT_W) || (flush_pend_q && (fill_q != '0));
  assign bus.out_last  = flush_pend_q && (fill_q <= C_OUT_W) && (fill_q != '0);
  assign bus.out_data  = acc_q[ACC_W-1 -: OUT_W];
  assign busy          = (fill_q != '0) || flush_pend_q;
  assign word_cnt      = word_cnt_q;

  assign w_push  = bus.in_valid && bus.in_ready;
  assign w_pop   = bus.out_valid && bus.out_ready;
  // A new field's LSB lands just above the OUT_W-fill still-empty bits.
  assign w_shift = C_OUT_W - fill_q;

  always_comb begin
    acc_d        = acc_q;
    fill_d       = fill_q;
    flush_pend_d = flush_pend_q;
    word_cnt_d   = word_cnt_q;

    if (w_push) begin
      acc_d  = (acc_q & ~(C_IN_MASK << w_shift)) | (ACC_W'(bus.in_data) << w_shift);
      fill_d = fill_q + C_IN_W;
    end else if (w_pop) begin
      acc_d      = (acc_q << OUT_W) | C_PAD_LOW;
      fill_d     = (fill_q >= C_OUT_W) ? (fill_q - C_OUT_W) : '0;
      word_cnt_d = word_cnt_q + 1'b1;
    end

    if (!flush_pend_q) begin
      flush_pend_d = bus.flush;
    end else if (fill_d == '0) begin
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= C_PAD_ALL;
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_field_packer.sv
// ============================================================================
// Module : tb_field_packer
// Brief  : Randomized scoreboard bench for field_packer with a bit-queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_field_packer;

  localparam int   IN_W  = 5;
  localparam int   OUT_W = 8;
  localparam logic PAD   = 1'b1;
  localparam int   CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             busy;
  logic [CNT_W-1:0] word_cnt;

  field_packer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  field_packer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .PAD_BIT(PAD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit               mq[$];
  logic [OUT_W:0]   exp_q[$];
  logic [CNT_W-1:0] cnt_model = '0;
  int               mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the frame is a plain bit queue; words are cut OUT_W bits at a time.
  task automatic model_emit(input bit fl);
    logic [OUT_W-1:0] w;
    while (mq.size() >= OUT_W) begin
      for (int i = 0; i < OUT_W; i++) w[OUT_W-1-i] = mq.pop_front();
      exp_q.push_back({fl && (mq.size() == 0), w});
    end
    if (fl && mq.size() > 0) begin
      w = {OUT_W{PAD}};
      for (int i = 0; i < mq.size(); i++) w[OUT_W-1-i] = mq[i];
      mq.delete();
      exp_q.push_back({1'b1, w});
    end
  endtask

  task automatic op(input bit do_push, input bit do_flush, input logic [IN_W-1:0] d);
    int t;
    @(negedge clk);
    t = 0;
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      bus.in_valid = do_push;
      bus.in_data  = d;
      bus.flush    = do_flush;
      if (do_push) for (int i = IN_W - 1; i >= 0; i--) mq.push_back(d[i]);
      model_emit(do_flush);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  task automatic wait_exp_empty(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("exp_empty_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted word.
  initial begin
    logic             prev_stall;
    logic [OUT_W-1:0] prev_data;
    logic             prev_last;
    logic [OUT_W:0]   e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
      #1;
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_data", 32'(bus.out_data), 32'(prev_data));
        chk("hold_last", 32'(bus.out_last), 32'(prev_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("word_cnt", 32'(word_cnt), 32'(cnt_model));
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", bus.out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e[OUT_W-1:0]));
          chk("out_last", 32'(bus.out_last), 32'(e[OUT_W]));
        end
        cnt_model = cnt_model + 1'b1;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_word_cnt",  32'(word_cnt),      32'd0);
    #2 rst_n = 1'b1;

    // Six alternating fields then flush: F8,3E,0F,83(last)
    for (int i = 0; i < 6; i++) op(1'b1, 1'b0, (i % 2 == 0) ? 5'h1F : 5'h00);
    op(1'b0, 1'b1, '0);
    wait_idle(200);
    chk("frame1_word_cnt", 32'(word_cnt), 32'd4);
    chk("frame1_busy",     32'(busy),     32'd0);

    // F8, 2A, AF(last)
    op(1'b1, 1'b0, 5'h1F); op(1'b1, 1'b0, 5'h00);
    op(1'b1, 1'b0, 5'h15); op(1'b1, 1'b0, 5'h0A);
    op(1'b0, 1'b1, '0);
    wait_idle(200);

    // Backpressure: F8 held for 10 cycles
    #2 mode = 2;
    op(1'b1, 1'b0, 5'h1F); op(1'b1, 1'b0, 5'h00);
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data",  32'(bus.out_data),  32'hF8);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      @(negedge clk);
      #1;
    end
    #1 mode = 0;
    @(negedge clk); @(negedge clk);
    #2 chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    op(1'b0, 1'b1, '0);
    wait_idle(200);

    // Flush with nothing buffered: busy one cycle, no word
    op(1'b0, 1'b1, '0);
    #1;
    chk("zflush_busy_hi",   32'(busy),          32'd1);
    chk("zflush_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("zflush_busy_lo",   32'(busy),          32'd0);
    chk("zflush_out_valid2", 32'(bus.out_valid), 32'd0);

    // Push and flush in the same cycle: FF(last)
    op(1'b1, 1'b1, 5'h1F);
    wait_idle(200);

    // Asynchronous reset mid-frame with a flush pending
    op(1'b1, 1'b0, 5'h1F); op(1'b1, 1'b0, 5'h00); op(1'b1, 1'b0, 5'h15);
    wait_exp_empty(200);
    #2 mode = 2;
    op(1'b0, 1'b1, '0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mrst_word_cnt",  32'(word_cnt),      32'd0);
    chk("mrst_busy",      32'(busy),          32'd0);
    mq.delete();
    exp_q.delete();
    cnt_model = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    mode = 0;
    op(1'b1, 1'b0, 5'h1F); op(1'b1, 1'b0, 5'h00);
    op(1'b0, 1'b1, '0);
    wait_idle(200);

    // Randomized traffic with random downstream stalls
    #2 mode = 1;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      op(1'b0, 1'b1, '0);
      else if (r == 1) op(1'b1, 1'b1, IN_W'($urandom));
      else             op(1'b1, 1'b0, IN_W'($urandom));
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    op(1'b0, 1'b1, '0);
    wait_idle(2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/field_packer.md
Name: field_packer

Overview:
- Streaming successor to the fixed six-field concatenator.
- Accepts IN_W-bit fields one per handshake and packs them MSB-first into a continuous bit stream.
- Emits OUT_W-bit words with valid/ready backpressure.
- A flush request closes the frame: residual bits are emitted as a final word, with the unused low bits filled with PAD_BIT, and that word is tagged out_last.

Parameters:
IN_W, 5, width of each input field (1..32)
OUT_W, 8, width of each output word (1..32)
PAD_BIT, 1'b1, value written into unused low bits of a partial (flushed) word
CNT_W, 16, width of the emitted-word counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  IN_W  field to pack; the first field of a frame lands in the MSBs
in_valid  input  1  in_data valid
in_ready  output  1  packer can accept a field this cycle
flush  input  1  single-cycle request to close the current frame
out_data  output  OUT_W  packed word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  qualifies out_data as the final word of a flushed frame
busy  output  1  fill != 0 or flush pending
word_cnt  output  CNT_W  count of words accepted downstream; wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Storage:
  - Accumulator acc, ACC_W = OUT_W + IN_W bits.
  - Fill counter fill, range 0..ACC_W-1.
  - Register flush_pending.
- Reset (async, any time, including mid-frame or mid-flush):
  - acc = all PAD_BIT; fill = 0; flush_pending = 0; word_cnt = 0.
  - Outputs: out_valid = 0, out_last = 0, in_ready = 1, busy = 0.
  - Partial data is discarded.
- Invariant: acc bits below the fill boundary always hold PAD_BIT.
- Input handshake:
  - in_ready = (fill < OUT_W) && !flush_pending. It is purely registered-state derived, with no combinational path from out_ready.
  - Push occurs when in_valid && in_ready.
  - On push: acc[ACC_W-1-fill -: IN_W] <= in_data; fill <= fill + IN_W.
- Output handshake:
  - out_valid = (fill >= OUT_W) || (flush_pending && fill != 0).
  - out_data = acc[ACC_W-1 -: OUT_W], combinational from registers. No latency beyond the register: a word is visible the cycle after the push that completes it.
  - Pop occurs when out_valid && out_ready. On pop: acc <= (acc << OUT_W) with the vacated low bits set to PAD_BIT; fill <= (fill >= OUT_W) ? fill - OUT_W : 0; word_cnt <= word_cnt + 1 (wraps).
  - out_data and out_last must hold stable while out_valid && !out_ready.
- Push and pop cannot coincide: push requires fill < OUT_W, and pop in that range requires flush_pending, which blocks push.
- Flush:
  - flush is sampled every cycle and sets flush_pending.
  - A field pushed in the same cycle as flush is included in the frame.
  - While pending, full words drain normally. The residual word (0 < fill <= OUT_W at emission) has its low bits already padded.
  - out_last = flush_pending && fill <= OUT_W && fill != 0.
  - flush_pending clears on the cycle fill reaches 0: either the pop of the out_last word, or the next cycle if flush arrives with fill == 0. A flush with fill == 0 therefore produces no word.
  - flush while already pending is ignored.
- Exact fit: if fill == OUT_W exactly when flush is pending, that word is emitted with out_last = 1 and carries no padding.
- Parameter constraints:
  - Synthesis/elab-time error if IN_W or OUT_W is outside 1..32.
  - IN_W > OUT_W is legal. Multiple words drain per field, and in_ready stays low until fill < OUT_W.

Test Plan:
- Defaults (IN_W=5, OUT_W=8, PAD_BIT=1). Push 1F,00,1F,00,1F,00 then flush, out_ready=1 → out_data F8,3E,0F,83. out_last only on 83. word_cnt=4. busy=0 afterwards.
- Push 1F,00 → F8 emitted, fill=2. Push 15 → no word, fill=7. Push 0A → 2A, fill=4. Flush → AF with out_last=1.
- Backpressure: hold out_ready=0 after the F8 word forms → out_valid=1, F8 stable for 10 cycles, in_ready=0. Release → F8 accepted once, in_ready=1 next cycle.
- Flush with fill=0 → no out_valid. busy high one cycle, then 0.
- Flush in the same cycle as a push of 1F from empty → word F8|07 = FF, out_last=1.
- Reset: assert rst_n=0 mid-frame (fill=7, flush pending) → out_valid=0, in_ready=1, word_cnt=0 immediately. The next push of 1F then 00 yields F8.
- Counter wrap: with CNT_W=4, emit 17 words → word_cnt=1.
